// File: rtl/imm_ext_pipe_pkg.sv
// Shared definitions for the registered immediate-extension pipeline stage.
// Holds the mode encodings and the pending-prefix depth helper.
package imm_ext_pipe_pkg;

    localparam logic [1:0] MODE_ZEXT  = 2'b00;
    localparam logic [1:0] MODE_SEXT  = 2'b01;
    localparam logic [1:0] MODE_PFX   = 2'b10;
    localparam logic [1:0] MODE_UPPER = 2'b11;

    // Most chunks that can be held while still leaving room for the final beat.
    function automatic int unsigned pfx_max_f(int unsigned in_w, int unsigned out_w);
        return (out_w - 1) / in_w;
    endfunction

endpackage

// File: rtl/imm_ext_core.sv
// Combinational extend unit: merges pending prefix chunks with the current immediate
// and zero/sign-extends or upper-places the result.
module imm_ext_core
    import imm_ext_pipe_pkg::*;
#(
    parameter int unsigned IN_W    = 6,
    parameter int unsigned OUT_W   = 16,
    parameter int unsigned PFX_MAX = pfx_max_f(IN_W, OUT_W),
    localparam int unsigned ACC_W  = PFX_MAX * IN_W,
    localparam int unsigned CNT_W  = $clog2(PFX_MAX + 1),
    localparam int unsigned CW     = ACC_W + IN_W
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [CNT_W-1:0] pfx_cnt,
    input  logic [IN_W-1:0]  data_in,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] result
);

    logic [CW-1:0]    comb;
    logic [OUT_W-1:0] ext;
    logic [OUT_W-1:0] upper;
    logic             sign_bit;
    int               wc;

    // Chunks above pfx_cnt are always zero, so the full concatenation is safe to use.
    assign comb  = {acc, data_in};
    assign upper = {data_in, {(OUT_W - IN_W){1'b0}}};

    always_comb begin
        sign_bit = 1'b0;
        wc       = IN_W * (int'(pfx_cnt) + 1);
        for (int k = 0; k <= int'(PFX_MAX); k++) begin
            if (int'(pfx_cnt) == k) begin
                sign_bit = comb[IN_W*(k+1)-1];
            end
        end
        ext = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            if (i < wc) begin
                ext[i] = comb[i];
            end else begin
                ext[i] = (mode == MODE_SEXT) && sign_bit;
            end
        end
    end

    assign result = (mode == MODE_UPPER) ? upper : ext;

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate-extension stage between decode and the operand mux, with
// prefix accumulation, a valid/ready output register and flush.
module imm_ext_pipe
    import imm_ext_pipe_pkg::*;
#(
    parameter int unsigned IN_W    = 6,
    parameter int unsigned OUT_W   = 16,
    localparam int unsigned PFX_MAX = pfx_max_f(IN_W, OUT_W),
    localparam int unsigned ACC_W   = PFX_MAX * IN_W,
    localparam int unsigned CNT_W   = $clog2(PFX_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode,
    input  logic [IN_W-1:0]  data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out,
    output logic [CNT_W-1:0] pfx_cnt,
    output logic             pfx_err
);

    logic             out_valid_q, out_valid_d;
    logic [OUT_W-1:0] data_out_q, data_out_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [OUT_W-1:0] core_result;
    logic [ACC_W-1:0] acc_shift;
    logic             accept;

    imm_ext_core #(
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .PFX_MAX (PFX_MAX)
    ) u_core (
        .acc     (acc_q),
        .pfx_cnt (cnt_q),
        .data_in (data_in),
        .mode    (mode),
        .result  (core_result)
    );

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready && !flush;
    // Truncating cast drops the oldest chunk once the accumulator is full.
    assign acc_shift = ACC_W'({acc_q, data_in});

    always_comb begin
        out_valid_d = out_valid_q;
        data_out_d  = data_out_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        err_d       = 1'b0;
        if (flush) begin
            out_valid_d = 1'b0;
            acc_d       = '0;
            cnt_d       = '0;
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
            end
            if (accept) begin
                if (mode == MODE_PFX) begin
                    acc_d = acc_shift;
                    if (cnt_q == CNT_W'(PFX_MAX)) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else begin
                    data_out_d  = core_result;
                    out_valid_d = 1'b1;
                    acc_d       = '0;
                    cnt_d       = '0;
                    err_d       = (mode == MODE_UPPER) && (cnt_q != '0);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign pfx_cnt   = cnt_q;
    assign pfx_err   = err_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe at IN_W=6, OUT_W=16.
module tb_imm_ext_pipe;
    import imm_ext_pipe_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic [5:0]  data_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;
    logic [1:0]  pfx_cnt;
    logic        pfx_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [5:0]  din;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[5];

    imm_ext_pipe #(
        .IN_W  (6),
        .OUT_W (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .pfx_cnt   (pfx_cnt),
        .pfx_err   (pfx_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic send(input logic [1:0] m, input logic [5:0] d);
        in_valid = 1'b1;
        mode     = m;
        data_in  = d;
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{MODE_SEXT,  6'b100001, 16'hFFE1};
        vecs[1] = '{MODE_SEXT,  6'b011111, 16'h001F};
        vecs[2] = '{MODE_ZEXT,  6'b111111, 16'h003F};
        vecs[3] = '{MODE_UPPER, 6'b000011, 16'h0C00};
        vecs[4] = '{MODE_ZEXT,  6'h05,     16'h0005};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; mode = 2'b00; data_in = '0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("reset out_valid", 32'(out_valid), 0);
        check("reset data_out", 32'(data_out), 0);
        check("reset pfx_cnt", 32'(pfx_cnt), 0);
        check("reset pfx_err", 32'(pfx_err), 0);
        check("reset in_ready", 32'(in_ready), 1);

        // Single-beat extension table
        for (int i = 0; i < 5; i++) begin
            send(vecs[i].mode, vecs[i].din);
            check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].exp));
            check($sformatf("vec%0d out_valid", i), 32'(out_valid), 1);
            check($sformatf("vec%0d pfx_err", i), 32'(pfx_err), 0);
            step();
            check($sformatf("vec%0d valid pulse", i), 32'(out_valid), 0);
        end

        // One prefix, sign then zero
        send(MODE_PFX, 6'b100000);
        check("pfx1 cnt", 32'(pfx_cnt), 1);
        check("pfx1 no output", 32'(out_valid), 0);
        send(MODE_SEXT, 6'b000000);
        check("pfx1 sext", 32'(data_out), 32'h0000_F800);
        check("pfx1 cnt after", 32'(pfx_cnt), 0);
        send(MODE_PFX, 6'b100000);
        send(MODE_ZEXT, 6'b000000);
        check("pfx1 zext", 32'(data_out), 32'h0000_0800);

        // Two prefixes: truncated, no extension
        send(MODE_PFX, 6'h01);
        send(MODE_PFX, 6'h02);
        check("pfx2 cnt", 32'(pfx_cnt), 2);
        check("pfx2 no err", 32'(pfx_err), 0);
        send(MODE_SEXT, 6'h03);
        check("pfx2 result", 32'(data_out), 32'h0000_1083);
        check("pfx2 err after", 32'(pfx_err), 0);

        // Overflow drops oldest chunk
        send(MODE_PFX, 6'h01);
        send(MODE_PFX, 6'h02);
        check("ovf no early err", 32'(pfx_err), 0);
        send(MODE_PFX, 6'h04);
        check("ovf err", 32'(pfx_err), 1);
        check("ovf cnt", 32'(pfx_cnt), 2);
        send(MODE_ZEXT, 6'h00);
        check("ovf result", 32'(data_out), 32'h0000_2100);
        check("ovf err pulse", 32'(pfx_err), 0);

        // Upper with a pending prefix
        send(MODE_PFX, 6'h01);
        send(MODE_UPPER, 6'b000011);
        check("upper pfx result", 32'(data_out), 32'h0000_0C00);
        check("upper pfx err", 32'(pfx_err), 1);
        check("upper pfx cnt", 32'(pfx_cnt), 0);
        step();
        check("upper err pulse", 32'(pfx_err), 0);

        // Backpressure: hold result, pending prefix then zero beat must wait
        out_ready = 1'b0;
        send(MODE_SEXT, 6'b100001);
        check("bp first", 32'(data_out), 32'h0000_FFE1);
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            mode    = (c < 2) ? MODE_PFX : MODE_ZEXT;
            data_in = (c < 2) ? 6'h2A : 6'h05;
            #1;
            check($sformatf("bp%0d in_ready", c), 32'(in_ready), 0);
            check($sformatf("bp%0d data_out", c), 32'(data_out), 32'h0000_FFE1);
            check($sformatf("bp%0d out_valid", c), 32'(out_valid), 1);
            check($sformatf("bp%0d pfx_cnt", c), 32'(pfx_cnt), 0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp release in_ready", 32'(in_ready), 1);
        step();
        in_valid = 1'b0;
        check("bp next data", 32'(data_out), 32'h0000_0005);
        check("bp next valid", 32'(out_valid), 1);
        step();

        // Flush wins over an accepted beat
        send(MODE_PFX, 6'h01);
        check("flush pre cnt", 32'(pfx_cnt), 1);
        flush = 1'b1;
        send(MODE_SEXT, 6'h3F);
        flush = 1'b0;
        check("flush no output", 32'(out_valid), 0);
        check("flush cnt", 32'(pfx_cnt), 0);
        check("flush no err", 32'(pfx_err), 0);
        send(MODE_SEXT, 6'h3F);
        check("post flush", 32'(data_out), 32'h0000_FFFF);
        check("post flush valid", 32'(out_valid), 1);

        // Reset mid-stall
        out_ready = 1'b0;
        send(MODE_SEXT, 6'b100001);
        check("stall before rst", 32'(out_valid), 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst stall valid", 32'(out_valid), 0);
        check("rst stall data", 32'(data_out), 0);
        check("rst stall in_ready", 32'(in_ready), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
